// File: rtl/frame_merge.sv
// Merges the ARP and IP transmit byte streams into one net tx stream.
// Arbitration is frame-atomic round-robin; short frames are zero-padded to MIN_FRAME_LEN.
module frame_merge #(
    parameter int MIN_FRAME_LEN = 60,
    parameter int CNT_WIDTH     = 11
) (
    input  logic       logic_clk,
    input  logic       logic_rst,
    input  logic [7:0] arp_tdata_in,
    input  logic       arp_tvalid_in,
    output logic       arp_tready_out,
    input  logic       arp_tlast_in,
    input  logic [7:0] ip_tdata_in,
    input  logic       ip_tvalid_in,
    output logic       ip_tready_out,
    input  logic       ip_tlast_in,
    output logic [7:0] net_tdata_out,
    output logic       net_tvalid_out,
    input  logic       net_tready_in,
    output logic       net_tlast_out,
    output logic       merge_busy_out
);

    // Handshake: a byte moves on any cycle where valid && ready. net_tdata_out,
    // net_tvalid_out and net_tlast_out depend only on state and the granted
    // source, never on net_tready_in; the granted source's tready follows
    // net_tready_in combinationally.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARP  = 2'd1,
        IP   = 2'd2,
        PAD  = 2'd3
    } state_t;

    localparam logic RR_ARP = 1'b0;
    localparam logic RR_IP  = 1'b1;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(MIN_FRAME_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rr_last_q, rr_last_d;

    logic [7:0] src_data;
    logic       src_valid;
    logic       src_last;
    logic       at_min;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rr_last_d      = rr_last_q;
        arp_tready_out = 1'b0;
        ip_tready_out  = 1'b0;
        net_tdata_out  = 8'h00;
        net_tvalid_out = 1'b0;
        net_tlast_out  = 1'b0;
        merge_busy_out = (state_q != IDLE);

        src_data  = (state_q == IP) ? ip_tdata_in  : arp_tdata_in;
        src_valid = (state_q == IP) ? ip_tvalid_in : arp_tvalid_in;
        src_last  = (state_q == IP) ? ip_tlast_in  : arp_tlast_in;
        at_min    = (cnt_q >= LAST_IDX);

        case (state_q)
            IDLE: begin
                // ARP wins when alone, or in a tie when IP was served last.
                if (arp_tvalid_in && (!ip_tvalid_in || rr_last_q == RR_IP)) begin
                    state_d   = ARP;
                    rr_last_d = RR_ARP;
                end else if (ip_tvalid_in) begin
                    state_d   = IP;
                    rr_last_d = RR_IP;
                end
            end

            ARP, IP: begin
                net_tdata_out  = src_data;
                net_tvalid_out = src_valid;
                net_tlast_out  = src_last && at_min;
                if (state_q == ARP) begin
                    arp_tready_out = net_tready_in;
                end else begin
                    ip_tready_out  = net_tready_in;
                end
                if (src_valid && net_tready_in) begin
                    if (src_last && at_min) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        if (src_last) begin
                            state_d = PAD;
                        end
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end

            PAD: begin
                net_tvalid_out = 1'b1;
                net_tlast_out  = (cnt_q == LAST_IDX);
                if (net_tready_in) begin
                    if (at_min) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rr_last_q <= RR_IP;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: tb/tb_frame_merge.sv
// Bench for frame_merge: table of single-source frames plus hand-written
// sequences for arbitration ties, downstream back-pressure and mid-frame reset.
module tb_frame_merge;
  localparam int MIN_LEN = 60;

  logic       logic_clk = 1'b0;
  logic       logic_rst;
  logic [7:0] arp_tdata_in;
  logic       arp_tvalid_in;
  logic       arp_tready_out;
  logic       arp_tlast_in;
  logic [7:0] ip_tdata_in;
  logic       ip_tvalid_in;
  logic       ip_tready_out;
  logic       ip_tlast_in;
  logic [7:0] net_tdata_out;
  logic       net_tvalid_out;
  logic       net_tready_in;
  logic       net_tlast_out;
  logic       merge_busy_out;

  // clock / reset
  always #5 logic_clk = ~logic_clk;

  frame_merge #(.MIN_FRAME_LEN(MIN_LEN), .CNT_WIDTH(11)) dut (
    .logic_clk      (logic_clk),
    .logic_rst      (logic_rst),
    .arp_tdata_in   (arp_tdata_in),
    .arp_tvalid_in  (arp_tvalid_in),
    .arp_tready_out (arp_tready_out),
    .arp_tlast_in   (arp_tlast_in),
    .ip_tdata_in    (ip_tdata_in),
    .ip_tvalid_in   (ip_tvalid_in),
    .ip_tready_out  (ip_tready_out),
    .ip_tlast_in    (ip_tlast_in),
    .net_tdata_out  (net_tdata_out),
    .net_tvalid_out (net_tvalid_out),
    .net_tready_in  (net_tready_in),
    .net_tlast_out  (net_tlast_out),
    .merge_busy_out (merge_busy_out)
  );

  int n_checks = 0;
  int n_fail = 0;
  int n_out = 0;
  logic [8:0] exp_q[$];   // {last, data}
  bit arp_only = 1'b0;
  bit prev_stall = 1'b0;
  bit after_last = 1'b0;
  logic [8:0] prev_out = '0;

  typedef struct {
    bit         is_ip;
    int         len;
    logic [7:0] base;
    int         exp_len;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every accepted output byte is compared against exp_q
  always @(negedge logic_clk) begin
    if (logic_rst) begin
      prev_stall = 1'b0;
      after_last = 1'b0;
    end else begin
      if (after_last) begin
        check("bubble_after_last", {30'd0, merge_busy_out, net_tvalid_out}, 32'd0);
        after_last = 1'b0;
      end
      if (prev_stall) begin
        check("stall_hold", {22'd0, net_tvalid_out, net_tlast_out, net_tdata_out}, {22'd0, 1'b1, prev_out});
      end
      if (arp_only) begin
        check("ip_ready_low", {31'd0, ip_tready_out}, 32'd0);
      end
      if (net_tvalid_out && net_tready_in) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no output at %0t", {net_tlast_out, net_tdata_out}, $time);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("out_byte", {23'd0, net_tlast_out, net_tdata_out}, {23'd0, e});
        end
        if (net_tlast_out) after_last = 1'b1;
      end
      prev_stall = net_tvalid_out && !net_tready_in;
      prev_out = {net_tlast_out, net_tdata_out};
    end
  end

  task automatic push_expected(input int len, input logic [7:0] base, input int out_len);
    for (int i = 0; i < out_len; i++) begin
      logic [7:0] d;
      d = (i < len) ? 8'(int'(base) + i) : 8'h00;
      exp_q.push_back({(i == out_len - 1), d});
    end
  endtask

  // driver: presents bytes base..base+len-1, advancing on each accepted byte
  task automatic send_frame(input bit is_ip, input int len, input logic [7:0] base);
    int i = 0;
    int budget = 0;
    bit took;
    while (i < len) begin
      if (is_ip) begin
        ip_tdata_in = 8'(int'(base) + i);
        ip_tvalid_in = 1'b1;
        ip_tlast_in = (i == len - 1);
      end else begin
        arp_tdata_in = 8'(int'(base) + i);
        arp_tvalid_in = 1'b1;
        arp_tlast_in = (i == len - 1);
      end
      @(negedge logic_clk);
      took = is_ip ? ip_tready_out : arp_tready_out;
      @(posedge logic_clk);
      #1;
      if (took) begin
        i++;
        budget = 0;
      end else begin
        budget++;
        if (budget > 300) begin
          n_checks++;
          n_fail++;
          $display("FAIL send_timeout: byte %0d of %0d not accepted, expected acceptance", i, len);
          break;
        end
      end
    end
    if (is_ip) begin
      ip_tvalid_in = 1'b0;
      ip_tlast_in = 1'b0;
    end else begin
      arp_tvalid_in = 1'b0;
      arp_tlast_in = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      @(posedge logic_clk);
      #1;
      budget++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (2) begin
      @(posedge logic_clk);
      #1;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tvalid"}, {31'd0, net_tvalid_out}, 32'd0);
    check({tag, "_tlast"}, {31'd0, net_tlast_out}, 32'd0);
    check({tag, "_tdata"}, {24'd0, net_tdata_out}, 32'd0);
    check({tag, "_arp_tready"}, {31'd0, arp_tready_out}, 32'd0);
    check({tag, "_ip_tready"}, {31'd0, ip_tready_out}, 32'd0);
    check({tag, "_busy"}, {31'd0, merge_busy_out}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int n0;
    bit done;

    vecs[0] = '{is_ip: 1'b0, len: 42, base: 8'h01, exp_len: 60};
    vecs[1] = '{is_ip: 1'b1, len: 64, base: 8'h10, exp_len: 64};
    vecs[2] = '{is_ip: 1'b1, len: 1,  base: 8'hAB, exp_len: 60};
    vecs[3] = '{is_ip: 1'b0, len: 60, base: 8'h40, exp_len: 60};
    vecs[4] = '{is_ip: 1'b1, len: 59, base: 8'h80, exp_len: 60};
    vecs[5] = '{is_ip: 1'b0, len: 61, base: 8'h20, exp_len: 61};
    vecs[6] = '{is_ip: 1'b1, len: 2,  base: 8'h55, exp_len: 60};

    logic_rst = 1'b1;
    arp_tdata_in = 8'h00;
    arp_tvalid_in = 1'b0;
    arp_tlast_in = 1'b0;
    ip_tdata_in = 8'h00;
    ip_tvalid_in = 1'b0;
    ip_tlast_in = 1'b0;
    net_tready_in = 1'b1;

    // reset state, with both sources requesting
    repeat (2) @(posedge logic_clk);
    #1;
    arp_tvalid_in = 1'b1;
    ip_tvalid_in = 1'b1;
    arp_tdata_in = 8'h5A;
    ip_tdata_in = 8'hA5;
    @(negedge logic_clk);
    check_idle_outputs("reset");
    @(posedge logic_clk);
    #1;
    arp_tvalid_in = 1'b0;
    ip_tvalid_in = 1'b0;
    logic_rst = 1'b0;

    // tie from reset: ARP first, then IP; second tie goes to ARP again
    push_expected(42, 8'h01, 60);
    push_expected(20, 8'h90, 60);
    arp_only = 1'b1;
    fork
      begin
        send_frame(1'b0, 42, 8'h01);
        arp_only = 1'b0;
      end
      send_frame(1'b1, 20, 8'h90);
    join
    wait_drain();

    push_expected(5, 8'hC0, 60);
    push_expected(60, 8'h00, 60);
    arp_only = 1'b1;
    fork
      begin
        send_frame(1'b0, 5, 8'hC0);
        arp_only = 1'b0;
      end
      send_frame(1'b1, 60, 8'h00);
    join
    wait_drain();

    // table of single-source frames
    for (int v = 0; v < 7; v++) begin
      n0 = n_out;
      push_expected(vecs[v].len, vecs[v].base, vecs[v].exp_len);
      send_frame(vecs[v].is_ip, vecs[v].len, vecs[v].base);
      wait_drain();
      check($sformatf("frame_len_%0d", v), n_out - n0, vecs[v].exp_len);
    end

    // padded ARP frame under random downstream back-pressure
    n0 = n_out;
    done = 1'b0;
    push_expected(42, 8'h30, 60);
    fork
      begin
        send_frame(1'b0, 42, 8'h30);
        wait_drain();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge logic_clk);
          #1;
          net_tready_in = 1'($urandom_range(0, 1));
        end
        net_tready_in = 1'b1;
      end
    join
    check("stall_frame_len", n_out - n0, 60);
    repeat (2) begin
      @(posedge logic_clk);
      #1;
    end

    // reset while byte 20 of an IP frame is on the bus
    for (int i = 0; i < 19; i++) exp_q.push_back({1'b0, 8'(8'h60 + i)});
    begin
      int i = 0;
      int budget = 0;
      bit took;
      while (i < 19 && budget < 50) begin
        ip_tdata_in = 8'(8'h60 + i);
        ip_tvalid_in = 1'b1;
        ip_tlast_in = 1'b0;
        @(negedge logic_clk);
        took = ip_tready_out;
        @(posedge logic_clk);
        #1;
        if (took) i++;
        budget++;
      end
      check("rst_prefix_sent", i, 19);
    end
    ip_tdata_in = 8'h73;
    logic_rst = 1'b1;
    @(posedge logic_clk);
    #1;
    logic_rst = 1'b0;
    ip_tvalid_in = 1'b0;
    @(negedge logic_clk);
    check_idle_outputs("midrst");
    check("midrst_abandoned", exp_q.size(), 0);
    @(posedge logic_clk);
    #1;

    n0 = n_out;
    push_expected(42, 8'h01, 60);
    send_frame(1'b0, 42, 8'h01);
    wait_drain();
    check("post_rst_frame_len", n_out - n0, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
